// File: rtl/rangefinder_vga_pkg.sv
// Shared definitions for the rangefinder VGA peripheral: register map,
// AXI response codes and the AXI4-Lite slave FSM encodings.
package rangefinder_vga_pkg;

    localparam logic [3:0] REG0_OFF  = 4'h0;
    localparam logic [3:0] REG1_OFF  = 4'h4;
    localparam logic [3:0] REG2_OFF  = 4'h8;
    localparam logic [3:0] REG3_OFF  = 4'hC;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    // Word-aligned offset to register index; every offset decodes.
    function automatic logic [1:0] reg_index(input logic [3:0] off);
        case (off)
            REG0_OFF: reg_index = 2'd0;
            REG1_OFF: reg_index = 2'd1;
            REG2_OFF: reg_index = 2'd2;
            REG3_OFF: reg_index = 2'd3;
            default:  reg_index = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/rangefinder_vga_axil_regs.sv
// AXI4-Lite slave holding the four VGA configuration registers, with a
// one-cycle commit strobe per register for the rendering logic.
module rangefinder_vga_axil_regs
    import rangefinder_vga_pkg::*;
#(
    parameter int C_DATA_WIDTH = 32,
    parameter int C_ADDR_WIDTH = 4
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [C_ADDR_WIDTH-1:0]   AWADDR,
    input  logic [2:0]                AWPROT,
    input  logic                      AWVALID,
    output logic                      AWREADY,
    input  logic [C_DATA_WIDTH-1:0]   WDATA,
    input  logic [C_DATA_WIDTH/8-1:0] WSTRB,
    input  logic                      WVALID,
    output logic                      WREADY,
    output logic [1:0]                BRESP,
    output logic                      BVALID,
    input  logic                      BREADY,
    input  logic [C_ADDR_WIDTH-1:0]   ARADDR,
    input  logic [2:0]                ARPROT,
    input  logic                      ARVALID,
    output logic                      ARREADY,
    output logic [C_DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]                RRESP,
    output logic                      RVALID,
    input  logic                      RREADY,
    output logic [C_DATA_WIDTH-1:0]   reg0_out,
    output logic [C_DATA_WIDTH-1:0]   reg1_out,
    output logic [C_DATA_WIDTH-1:0]   reg2_out,
    output logic [C_DATA_WIDTH-1:0]   reg3_out,
    output logic [3:0]                reg_wr_pulse
);

    w_state_t w_state, w_state_next;
    r_state_t r_state, r_state_next;

    logic                    aw_ready_q;
    logic                    ar_ready_q;
    logic                    wr_hs;
    logic                    rd_hs;
    logic [1:0]              wr_idx;
    logic [1:0]              rd_idx;
    logic [C_DATA_WIDTH-1:0] rdata_q;
    logic [C_DATA_WIDTH-1:0] regs [4];

    logic unused_inputs;
    assign unused_inputs = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0]};

    function automatic logic [C_DATA_WIDTH-1:0] merge_lanes(
        input logic [C_DATA_WIDTH-1:0]   old_val,
        input logic [C_DATA_WIDTH-1:0]   new_val,
        input logic [C_DATA_WIDTH/8-1:0] strb
    );
        merge_lanes = old_val;
        for (int i = 0; i < C_DATA_WIDTH/8; i++) begin
            if (strb[i]) merge_lanes[8*i +: 8] = new_val[8*i +: 8];
        end
    endfunction

    // Ready is a registered one-cycle pulse, so a handshake is ready plus valid.
    assign wr_hs  = aw_ready_q && AWVALID && WVALID;
    assign rd_hs  = ar_ready_q && ARVALID;
    assign wr_idx = reg_index({AWADDR[3:2], 2'b00});
    assign rd_idx = reg_index({ARADDR[3:2], 2'b00});

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_state_next;
            r_state <= r_state_next;
        end
    end

    // NOTE: every variable gets a default first so no latch is inferred.
    always_comb begin
        w_state_next = w_state;
        r_state_next = r_state;
        case (w_state)
            W_IDLE: if (wr_hs)  w_state_next = W_RESP;
            W_RESP: if (BREADY) w_state_next = W_IDLE;
        endcase
        case (r_state)
            R_IDLE: if (rd_hs)  r_state_next = R_DATA;
            R_DATA: if (RREADY) r_state_next = R_IDLE;
        endcase
    end

    always_comb begin
        BVALID = (w_state == W_RESP);
        RVALID = (r_state == R_DATA);
    end

    // NOTE: non-blocking assignments give the same-edge read the pre-write value.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_ready_q   <= 1'b0;
            ar_ready_q   <= 1'b0;
            reg_wr_pulse <= '0;
            rdata_q      <= '0;
            // NOTE: the register file is reset because software reads it back as zero.
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            aw_ready_q   <= (w_state == W_IDLE) && !aw_ready_q && AWVALID && WVALID;
            ar_ready_q   <= (r_state == R_IDLE) && !ar_ready_q && ARVALID;
            reg_wr_pulse <= '0;
            if (wr_hs) begin
                regs[wr_idx] <= merge_lanes(regs[wr_idx], WDATA, WSTRB);
                reg_wr_pulse <= 4'b0001 << wr_idx;
            end
            if (rd_hs) rdata_q <= regs[rd_idx];
        end
    end

    assign AWREADY  = aw_ready_q;
    assign WREADY   = aw_ready_q;
    assign ARREADY  = ar_ready_q;
    assign BRESP    = RESP_OKAY;
    assign RRESP    = RESP_OKAY;
    assign RDATA    = rdata_q;
    assign reg0_out = regs[0];
    assign reg1_out = regs[1];
    assign reg2_out = regs[2];
    assign reg3_out = regs[3];

endmodule

// File: tb/tb_rangefinder_vga_axil_regs.sv
// Directed plus randomized bench for the rangefinder VGA AXI4-Lite register
// bank, checked against a word/byte-mask reference model of the register map.
module tb_rangefinder_vga_axil_regs;

    logic        tb_ACLK = 1'b0;
    logic        ARESET;
    logic [3:0]  AWADDR;
    logic [2:0]  AWPROT;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [3:0]  ARADDR;
    logic [2:0]  ARPROT;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;
    logic [31:0] reg0_out, reg1_out, reg2_out, reg3_out;
    logic [3:0]  reg_wr_pulse;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] model_regs [4];

    rangefinder_vga_axil_regs #(.C_DATA_WIDTH(32), .C_ADDR_WIDTH(4)) dut (
        .ACLK(tb_ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .reg0_out(reg0_out), .reg1_out(reg1_out), .reg2_out(reg2_out),
        .reg3_out(reg3_out), .reg_wr_pulse(reg_wr_pulse)
    );

    always #5 tb_ACLK = ~tb_ACLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: register index is the word number, strobes form a byte mask.
    function automatic int word_of(input logic [3:0] addr);
        return (int'(addr) / 4) % 4;
    endfunction

    task automatic model_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] mask;
        mask = 32'h0;
        for (int b = 0; b < 4; b++) if (strb[b]) mask = mask | (32'hFF << (8 * b));
        model_regs[word_of(addr)] = (model_regs[word_of(addr)] & ~mask) | (data & mask);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) model_regs[i] = 32'h0;
    endtask

    task automatic check_regs(input string tag);
        check({tag, " reg0"}, reg0_out, model_regs[0]);
        check({tag, " reg1"}, reg1_out, model_regs[1]);
        check({tag, " reg2"}, reg2_out, model_regs[2]);
        check({tag, " reg3"}, reg3_out, model_regs[3]);
    endtask

    task automatic tick();
        @(posedge tb_ACLK);
        #1;
    endtask

    // Full write with BREADY held high; checks latency, response and strobe.
    task automatic do_write(input logic [3:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input string tag);
        int n;
        n = 0;
        AWADDR = addr; WDATA = data; WSTRB = strb;
        AWVALID = 1'b1; WVALID = 1'b1;
        do begin
            tick();
            n++;
        end while (!(AWREADY && WREADY) && n < 16);
        check({tag, " aw/w ready latency"}, n, 1);
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        model_write(addr, data, strb);
        check({tag, " bvalid"}, BVALID, 1'b1);
        check({tag, " bresp"}, BRESP, 2'b00);
        check({tag, " wr pulse"}, reg_wr_pulse, 32'(1) << word_of(addr));
        tick();
        check({tag, " bvalid clear"}, BVALID, 1'b0);
        check({tag, " wr pulse clear"}, reg_wr_pulse, 4'b0000);
    endtask

    // Full read with RREADY held high; compares against the model.
    task automatic do_read(input logic [3:0] addr, input string tag);
        int n;
        logic [31:0] exp;
        n = 0;
        exp = model_regs[word_of(addr)];
        ARADDR = addr;
        ARVALID = 1'b1;
        do begin
            tick();
            n++;
        end while (!ARREADY && n < 16);
        check({tag, " ar ready latency"}, n, 1);
        tick();
        ARVALID = 1'b0;
        check({tag, " rvalid"}, RVALID, 1'b1);
        check({tag, " rdata"}, RDATA, exp);
        check({tag, " rresp"}, RRESP, 2'b00);
        tick();
        check({tag, " rvalid clear"}, RVALID, 1'b0);
    endtask

    // One channel leads the other by `lead` cycles; both readies must pulse once, together.
    task automatic order_write(input bit aw_first, input int lead, input logic [3:0] addr,
                               input logic [31:0] data, input string tag);
        int aw_cnt, w_cnt, both_cnt;
        bit pending;
        aw_cnt = 0; w_cnt = 0; both_cnt = 0; pending = 0;
        AWADDR = addr; WDATA = data; WSTRB = 4'hF;
        if (aw_first) AWVALID = 1'b1;
        else          WVALID  = 1'b1;
        for (int k = 0; k < lead; k++) begin
            tick();
            check({tag, " no early accept"}, {AWREADY, WREADY}, 2'b00);
        end
        AWVALID = 1'b1; WVALID = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (pending) begin
                AWVALID = 1'b0; WVALID = 1'b0; pending = 0;
            end
            if (AWREADY) aw_cnt++;
            if (WREADY) w_cnt++;
            if (AWREADY && WREADY) begin
                both_cnt++;
                pending = 1;
            end
        end
        AWVALID = 1'b0; WVALID = 1'b0;
        model_write(addr, data, 4'hF);
        check({tag, " awready count"}, aw_cnt, 1);
        check({tag, " wready count"}, w_cnt, 1);
        check({tag, " same-cycle count"}, both_cnt, 1);
        check_regs(tag);
    endtask

    initial begin
        logic [31:0] held;
        logic [3:0]  a;

        ARESET = 1'b1;
        AWADDR = '0; AWPROT = '0; AWVALID = 0; WDATA = '0; WSTRB = '0; WVALID = 0;
        BREADY = 1'b1; ARADDR = '0; ARPROT = '0; ARVALID = 0; RREADY = 1'b1;
        model_clear();

        // Outputs stay at zero through reset even with requests pending.
        tick();
        AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1; WDATA = 32'hFFFF_FFFF; WSTRB = 4'hF;
        repeat (3) tick();
        check("rst handshake readies", {AWREADY, WREADY, ARREADY}, 3'b000);
        check("rst valids", {BVALID, RVALID}, 2'b00);
        check("rst resp", {BRESP, RRESP}, 4'b0000);
        check("rst rdata", RDATA, 32'h0);
        check("rst wr pulse", reg_wr_pulse, 4'b0000);
        check_regs("rst");
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        ARESET = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) begin
            a = 4'(i * 4);
            do_read(a, $sformatf("reset read %0d", i));
        end

        do_write(4'h0, 32'h0101_FFFF, 4'hF, "wr reg0");
        do_write(4'h4, 32'hABCD_0001, 4'hF, "wr reg1");
        do_write(4'h8, 32'hDEAD_0011, 4'hF, "wr reg2");
        do_write(4'hC, 32'hBEEF_0011, 4'hF, "wr reg3");
        check_regs("after plan writes");
        for (int i = 0; i < 4; i++) begin
            a = 4'(i * 4);
            do_read(a, $sformatf("readback %0d", i));
        end

        order_write(1'b0, 3, 4'h8, 32'h5A5A_1234, "w before aw");
        order_write(1'b1, 2, 4'hC, 32'h0F0F_C3C3, "aw before w");
        do_read(4'h8, "order rd reg2");
        do_read(4'hC, "order rd reg3");

        do_write(4'h4, 32'h1122_3344, 4'b0101, "strb 0101");
        check("strb merge constant", reg1_out, 32'hAB22_0044);
        do_read(4'h4, "strb rd reg1");
        do_write(4'h5, 32'hFFFF_FFFF, 4'b0000, "strb none");
        check("strb none unchanged", reg1_out, 32'hAB22_0044);

        // Write response back-pressure; a second write waits for the B handshake.
        BREADY = 1'b0;
        AWADDR = 4'h0; WDATA = 32'hCAFE_0001; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
        tick();
        check("bp w ready", {AWREADY, WREADY}, 2'b11);
        tick();
        model_write(4'h0, 32'hCAFE_0001, 4'hF);
        AWADDR = 4'h4; WDATA = 32'h0000_BEEF; WSTRB = 4'b0011;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp bvalid hold %0d", k), BVALID, 1'b1);
            check($sformatf("bp no accept %0d", k), {AWREADY, WREADY}, 2'b00);
            check($sformatf("bp pulse %0d", k), reg_wr_pulse, (k == 0) ? 4'b0001 : 4'b0000);
            tick();
        end
        BREADY = 1'b1;
        tick();
        check("bp b done", BVALID, 1'b0);
        check("bp not yet ready", {AWREADY, WREADY}, 2'b00);
        tick();
        check("bp second ready", {AWREADY, WREADY}, 2'b11);
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        model_write(4'h4, 32'h0000_BEEF, 4'b0011);
        check("bp second bvalid", BVALID, 1'b1);
        check("bp second pulse", reg_wr_pulse, 4'b0010);
        tick();
        check_regs("bp write");

        // Read data back-pressure; RDATA held and a second AR waits.
        RREADY = 1'b0;
        ARADDR = 4'h0; ARVALID = 1'b1;
        tick();
        check("bp ar ready", ARREADY, 1'b1);
        tick();
        held = model_regs[0];
        ARADDR = 4'h4;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("bp rvalid hold %0d", k), RVALID, 1'b1);
            check($sformatf("bp rdata hold %0d", k), RDATA, held);
            check($sformatf("bp no ar accept %0d", k), ARREADY, 1'b0);
            tick();
        end
        RREADY = 1'b1;
        tick();
        check("bp r done", RVALID, 1'b0);
        check("bp ar not yet", ARREADY, 1'b0);
        tick();
        check("bp second ar ready", ARREADY, 1'b1);
        tick();
        ARVALID = 1'b0;
        check("bp second rvalid", RVALID, 1'b1);
        check("bp second rdata", RDATA, model_regs[1]);
        tick();

        // Read and write to the same register handshaking on the same edge.
        held = model_regs[3];
        AWADDR = 4'hC; WDATA = 32'h7766_5544; WSTRB = 4'hF; ARADDR = 4'hC;
        AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
        tick();
        check("coll readies", {AWREADY, WREADY, ARREADY}, 3'b111);
        tick();
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        check("coll old rdata", RDATA, held);
        check("coll valids", {BVALID, RVALID}, 2'b11);
        model_write(4'hC, 32'h7766_5544, 4'hF);
        tick();
        do_read(4'hC, "coll new rdata");

        // Reset with both responses outstanding.
        BREADY = 1'b0; RREADY = 1'b0;
        AWADDR = 4'h8; WDATA = 32'h1234_5678; WSTRB = 4'hF; ARADDR = 4'h8;
        AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
        tick();
        tick();
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        check("pre-reset valids", {BVALID, RVALID}, 2'b11);
        ARESET = 1'b1;
        #1;
        model_clear();
        check("async reset valids", {BVALID, RVALID}, 2'b00);
        check("async reset rdata", RDATA, 32'h0);
        check_regs("async reset");
        tick();
        ARESET = 1'b0;
        BREADY = 1'b1; RREADY = 1'b1;
        tick();
        do_write(4'h8, 32'h00C0_FFEE, 4'hF, "post-reset wr");
        do_read(4'h8, "post-reset rd reg2");
        do_read(4'h0, "post-reset rd reg0");

        // Randomized traffic, including ignored low address bits.
        for (int t = 0; t < 30; t++) begin
            do_write(4'($urandom), $urandom, 4'($urandom), $sformatf("rand wr %0d", t));
            do_read(4'($urandom), $sformatf("rand rd %0d", t));
        end
        check_regs("final");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/rangefinder_vga_axil_regs.md
# rangefinder_vga_axil_regs

AXI4-Lite slave register bank terminating the S00_AXI port of the rangefinder VGA peripheral. It is the responder for the AXI4-Lite master BFM used in the block-design bench. It holds four 32-bit read/write configuration registers at offsets 0x0, 0x4, 0x8 and 0xC. Register contents, plus a per-register write-commit strobe, are presented to the VGA rendering logic.

## Interface
- C_DATA_WIDTH, 32: AXI data width; only 32 is supported.
- C_ADDR_WIDTH, 4: AXI address width; bits [3:2] select the register, bits [1:0] are ignored.
- ACLK  in  1  single clock; all logic is on the rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- AWADDR  in  C_ADDR_WIDTH; AWPROT  in  3 (ignored); AWVALID  in  1; AWREADY  out  1.
- WDATA  in  32; WSTRB  in  4; WVALID  in  1; WREADY  out  1.
- BRESP  out  2; BVALID  out  1; BREADY  in  1.
- ARADDR  in  C_ADDR_WIDTH; ARPROT  in  3 (ignored); ARVALID  in  1; ARREADY  out  1.
- RDATA  out  32; RRESP  out  2; RVALID  out  1; RREADY  in  1.
- reg0_out, reg1_out, reg2_out, reg3_out  out  32 each  current register contents.
- reg_wr_pulse  out  4  one-hot, one-cycle strobe, asserted the cycle after a write commits to register n.

## Operation
- Write FSM has two states, W_IDLE and W_RESP.
  - In W_IDLE, once AWVALID and WVALID are both high, AWREADY and WREADY are asserted together for exactly one cycle. The write commits on that handshake edge, and the FSM moves to W_RESP with BVALID=1.
  - In W_RESP, BVALID is held until BREADY is sampled high, then the FSM returns to W_IDLE.
  - AW and W may arrive in either order or in the same cycle. Neither is accepted alone.
- Byte-lane merge on commit: for each i, byte i of reg[AWADDR[3:2]] takes WDATA byte i if WSTRB[i]=1; otherwise it is unchanged. WSTRB=0 commits nothing to the register, but the write still receives a response and still produces reg_wr_pulse.
- Read FSM has two states, R_IDLE and R_DATA.
  - In R_IDLE, when ARVALID is high, ARREADY is asserted for one cycle. RDATA is loaded on that handshake edge, and the FSM moves to R_DATA with RVALID=1.
  - In R_DATA, RDATA and RVALID are held stable until RREADY is sampled high.
- BRESP and RRESP are always 2'b00 (OKAY). There are no error responses, and every offset decodes.
- The read and write channels are independent; at most one write and one read are outstanding at a time.

## Timing
- Reset (asynchronous assert, synchronous to ACLK on release):
  - AWREADY, WREADY, ARREADY, BVALID, RVALID and reg_wr_pulse = 0.
  - BRESP = RRESP = 0, RDATA = 0, all registers = 0.
  - Any in-flight transaction is dropped; both FSMs return to idle.
- Write latency:
  - cycle 0: AWVALID and WVALID both high.
  - cycle 1: AWREADY and WREADY high; the register updates at the end of cycle 1.
  - cycle 2: BVALID high; reg_wr_pulse high for this cycle only.
- Write acceptance is blocked while BVALID=1, so a new AW/W waits until the cycle after the B handshake.
- Read latency:
  - cycle 0: ARVALID high.
  - cycle 1: ARREADY high.
  - cycle 2: RVALID high with data.
- ARREADY is not asserted while RVALID=1.
- Simultaneous read and write to the same register: if the ARREADY and AWREADY/WREADY handshakes occur on the same edge, RDATA returns the value from before the write. A read handshaking on a later edge returns the new value.
- Back-to-back throughput: one write per 3 cycles when BREADY is tied high; likewise one read per 3 cycles when RREADY is tied high.
- Outputs are not combinationally dependent on any input.

## Structure
- Shared package rangefinder_vga_pkg holds:
  - the register offset localparams (REG0_OFF=4'h0 through REG3_OFF=4'hC);
  - RESP_OKAY=2'b00;
  - the write-FSM and read-FSM state encodings.
- No sub-module. The byte-lane merge is a local function inside the block.

## Test plan
- Reset then read all four offsets -> RDATA=0x00000000, RRESP=OKAY on each; every output is 0 while ARESET is high.
- Write then read back 0x0101FFFF, 0xABCD0001, 0xDEAD0011 and 0xBEEF0011 to offsets 0x0, 0x4, 0x8 and 0xC -> each readback matches, BRESP=OKAY, reg_wr_pulse = 0001, 0010, 0100, 1000 in turn.
- W presented 3 cycles before AW, then AW presented 2 cycles before W -> AWREADY and WREADY are each asserted once, in the same cycle; data commits correctly in both orders.
- With reg1=0xABCD0001, write 0x11223344 with WSTRB=4'b0101 -> reg1=0xAB220044.
- Hold BREADY low for 5 cycles and RREADY low for 4 cycles -> BVALID, RVALID and RDATA are held stable; no new AW/W/AR is accepted until the respective handshake completes.
- Assert ARESET while BVALID=1 and RVALID=1 -> both drop immediately, registers clear to 0, and the next write/read completes normally.
